// File: rtl/codec_i2c_cmd_regs_if.sv
// Register bus plus command/response bus for the codec I2C command block.
// slave  : the register block (decodes register accesses, issues commands).
// master : the host/controller side (drives register accesses, accepts
//          commands, returns responses).
interface codec_i2c_cmd_regs_if #(
    parameter int NUM_DEV = 2
);
    localparam int DEV_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    // register access
    logic [31:0]      data_in;
    logic [31:0]      data_out;
    logic [5:0]       reg_addr;
    logic             data_wren;
    logic [3:0]       byte_enable;
    // command issue
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_rnw;
    logic [DEV_W-1:0] cmd_dev;
    logic [7:0]       cmd_addr;
    logic [31:0]      cmd_wdata;
    // response return
    logic             rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             irq;

    modport slave (
        input  data_in, reg_addr, data_wren, byte_enable,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output data_out, cmd_valid, cmd_rnw, cmd_dev, cmd_addr, cmd_wdata, irq
    );

    modport master (
        output data_in, reg_addr, data_wren, byte_enable,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  data_out, cmd_valid, cmd_rnw, cmd_dev, cmd_addr, cmd_wdata, irq
    );
endinterface

// File: rtl/codec_i2c_cmd_regs.sv
// Codec I2C command register block.
// Host writes ADDR/WDATA and kicks CTRL to queue read/write commands into a
// first-word-fall-through FIFO; the head is issued on cmd_* with a
// valid/ready handshake, one transaction in flight at a time. Responses load
// RDATA (reads only) and set sticky STATUS bits; irq = |(STATUS & IRQ_EN),
// registered.
// Ports:
//   axi_clk   - clock, rising edge
//   axi_reset - synchronous active-high reset
//   bus       - register bus, command and response signals (slave side)
module codec_i2c_cmd_regs #(
    parameter int NUM_DEV   = 2,
    parameter int CMD_DEPTH = 4
) (
    input logic                 axi_clk,
    input logic                 axi_reset,
    codec_i2c_cmd_regs_if.slave bus
);
    localparam int DEV_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int AW    = $clog2(CMD_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_ADDR   = 6'h01;
    localparam logic [5:0] A_WDATA  = 6'h02;
    localparam logic [5:0] A_RDATA  = 6'h03;
    localparam logic [5:0] A_STATUS = 6'h04;
    localparam logic [5:0] A_IRQEN  = 6'h05;
    localparam logic [5:0] A_PARAM  = 6'h06;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           state, state_next;
    logic [7:0]       addr_reg;
    logic [DEV_W-1:0] dev_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      rdata_reg;
    logic [3:0]       status;
    logic [3:0]       irq_en;
    logic             irq_q;
    logic             inflight_rnw;

    logic             mem_rnw   [CMD_DEPTH];
    logic [DEV_W-1:0] mem_dev   [CMD_DEPTH];
    logic [7:0]       mem_addr  [CMD_DEPTH];
    logic [31:0]      mem_wdata [CMD_DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;

    logic        empty, full, busy, pop;
    logic        ctrl_wr, push_req, push_ok, bad_cmd, overflow, rsp_fire;
    logic [31:0] lane_mask, addr_cur, addr_new, wdata_new;
    logic [3:0]  status_set, status_clr;

    assign empty = (count == '0);
    assign full  = (count == CW'(CMD_DEPTH));
    assign busy  = (state == ST_BUSY);

    assign lane_mask = {{8{bus.byte_enable[3]}}, {8{bus.byte_enable[2]}},
                        {8{bus.byte_enable[1]}}, {8{bus.byte_enable[0]}}};

    // ADDR is handled as a 32-bit word so lane masking applies uniformly to
    // the address and device fields; unused bits are simply not kept.
    always_comb begin
        addr_cur                = '0;
        addr_cur[7:0]           = addr_reg;
        addr_cur[16 +: DEV_W]   = dev_reg;
    end
    assign addr_new  = (addr_cur & ~lane_mask) | (bus.data_in & lane_mask);
    assign wdata_new = (wdata_reg & ~lane_mask) | (bus.data_in & lane_mask);

    assign ctrl_wr  = bus.data_wren && (bus.reg_addr == A_CTRL) && bus.byte_enable[0];
    assign push_req = ctrl_wr && (bus.data_in[0] ^ bus.data_in[1]);
    assign bad_cmd  = ctrl_wr && bus.data_in[0] && bus.data_in[1];
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign overflow = push_req && full && !pop;
    assign rsp_fire = bus.rsp_valid && busy;

    // In-flight tracking FSM
    always_ff @(posedge axi_clk) begin
        if (axi_reset) state <= ST_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.cmd_valid = 1'b0;
        pop           = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.cmd_valid = !empty;
                pop           = !empty && bus.cmd_ready;
                if (pop) state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.rsp_valid) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Head of FIFO drives the command bus directly (fall-through).
    assign bus.cmd_rnw   = mem_rnw[rptr];
    assign bus.cmd_dev   = mem_dev[rptr];
    assign bus.cmd_addr  = mem_addr[rptr];
    assign bus.cmd_wdata = mem_wdata[rptr];

    always_ff @(posedge axi_clk) begin
        if (push_ok) begin
            mem_rnw[wptr]   <= bus.data_in[1];
            mem_dev[wptr]   <= dev_reg;
            mem_addr[wptr]  <= addr_reg;
            mem_wdata[wptr] <= wdata_reg;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            inflight_rnw <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr         <= rptr + 1'b1;
                inflight_rnw <= mem_rnw[rptr];
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign status_set = {bad_cmd, overflow, rsp_fire && bus.rsp_err, rsp_fire};
    assign status_clr = (bus.data_wren && (bus.reg_addr == A_STATUS) && bus.byte_enable[0])
                        ? bus.data_in[3:0] : 4'h0;

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            addr_reg  <= '0;
            dev_reg   <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            status    <= '0;
            irq_en    <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (bus.data_wren && bus.reg_addr == A_ADDR) begin
                addr_reg <= addr_new[7:0];
                dev_reg  <= addr_new[16 +: DEV_W];
            end
            if (bus.data_wren && bus.reg_addr == A_WDATA)
                wdata_reg <= wdata_new;
            if (bus.data_wren && bus.reg_addr == A_IRQEN && bus.byte_enable[0])
                irq_en <= bus.data_in[3:0];
            if (rsp_fire && inflight_rnw && !bus.rsp_err)
                rdata_reg <= bus.rsp_rdata;
            // set wins over a simultaneous clear
            status <= (status & ~status_clr) | status_set;
            irq_q  <= |(status & irq_en);
        end
    end

    assign bus.irq = irq_q;

    always_comb begin
        bus.data_out = 32'hDEAD_BEEF;
        case (bus.reg_addr)
            A_CTRL:   bus.data_out = {16'h0, 8'(count), 5'h0, busy, full, !empty};
            A_ADDR:   bus.data_out = addr_cur;
            A_WDATA:  bus.data_out = wdata_reg;
            A_RDATA:  bus.data_out = rdata_reg;
            A_STATUS: bus.data_out = {28'h0, status};
            A_IRQEN:  bus.data_out = {28'h0, irq_en};
            A_PARAM:  bus.data_out = {16'h0, 8'(CMD_DEPTH), 8'(NUM_DEV)};
            default:  bus.data_out = 32'hDEAD_BEEF;
        endcase
    end
endmodule
